// File: rtl/datapath_pkg.sv
// datapath_pkg: shared widths, control-word field positions, FS codes and the
// decoded control-word type used by datapath_top and datapath_alu.
package datapath_pkg;

    localparam int unsigned DataW    = 32;
    localparam int unsigned RegAddrW = 4;
    localparam int unsigned MemAddrW = 8;
    localparam int unsigned NumRegs  = 16;
    localparam int unsigned MemDepth = 256;
    localparam int unsigned FsW      = 5;
    localparam int unsigned CwW      = 55;

    // Control-word field positions (LSB of multi-bit fields)
    localparam int unsigned CwDaLsb = 51;
    localparam int unsigned CwAaLsb = 47;
    localparam int unsigned CwBaLsb = 43;
    localparam int unsigned CwMbBit = 42;
    localparam int unsigned CwFsLsb = 37;
    localparam int unsigned CwMdBit = 36;
    localparam int unsigned CwRwBit = 35;
    localparam int unsigned CwMwBit = 34;
    localparam int unsigned CwSeBit = 33;
    localparam int unsigned CwKLsb  = 0;

    // Function-select codes
    localparam logic [FsW-1:0] FsPassA  = 5'b00000;
    localparam logic [FsW-1:0] FsInc    = 5'b00001;
    localparam logic [FsW-1:0] FsAdd    = 5'b00010;
    localparam logic [FsW-1:0] FsAddInc = 5'b00011;
    localparam logic [FsW-1:0] FsAddNot = 5'b00100;
    localparam logic [FsW-1:0] FsSub    = 5'b00101;
    localparam logic [FsW-1:0] FsDec    = 5'b00110;
    localparam logic [FsW-1:0] FsPassA2 = 5'b00111;
    localparam logic [FsW-1:0] FsAnd    = 5'b01000;
    localparam logic [FsW-1:0] FsOr     = 5'b01001;
    localparam logic [FsW-1:0] FsXor    = 5'b01010;
    localparam logic [FsW-1:0] FsNotA   = 5'b01011;
    localparam logic [FsW-1:0] FsPassB  = 5'b01100;
    localparam logic [FsW-1:0] FsLsr    = 5'b01101;
    localparam logic [FsW-1:0] FsShl    = 5'b01110;
    localparam logic [FsW-1:0] FsAsr    = 5'b01111;
    localparam logic [FsW-1:0] FsSlt    = 5'b10000;
    localparam logic [FsW-1:0] FsSltu   = 5'b10001;

    typedef struct packed {
        logic [RegAddrW-1:0] da;
        logic [RegAddrW-1:0] aa;
        logic [RegAddrW-1:0] ba;
        logic                mb;
        logic [FsW-1:0]      fs;
        logic                md;
        logic                rw;
        logic                mw;
        logic                se;
        logic [DataW-1:0]    k;
    } cw_t;

    // Bit 32 of the control word is reserved and deliberately not decoded.
    function automatic cw_t decode_cw(input logic [CwW-1:0] w);
        cw_t c;
        c.da = w[CwDaLsb +: RegAddrW];
        c.aa = w[CwAaLsb +: RegAddrW];
        c.ba = w[CwBaLsb +: RegAddrW];
        c.mb = w[CwMbBit];
        c.fs = w[CwFsLsb +: FsW];
        c.md = w[CwMdBit];
        c.rw = w[CwRwBit];
        c.mw = w[CwMwBit];
        c.se = w[CwSeBit];
        c.k  = w[CwKLsb +: DataW];
        return c;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational 32-bit ALU/shifter with V/C/N/Z flags.
// Ports:
//   a_i, b_i : operands
//   fs_i     : function select
//   f_o      : result
//   v_o, c_o : signed overflow / carry (adder) or shifted-out bit (shifts)
//   n_o, z_o : result sign / result zero
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    input  logic [FsW-1:0]   fs_i,
    output logic [DataW-1:0] f_o,
    output logic             v_o,
    output logic             c_o,
    output logic             n_o,
    output logic             z_o
);

    logic [DataW-1:0] b_op;
    logic             cin;
    logic             is_add;
    logic [DataW:0]   sum;
    logic             add_ovf;

    // All adder ops share one A + b_op + cin adder.
    always_comb begin
        b_op   = '0;
        cin    = 1'b0;
        is_add = 1'b1;
        case (fs_i)
            FsInc:    begin b_op = '0;    cin = 1'b1; end
            FsAdd:    begin b_op = b_i;   cin = 1'b0; end
            FsAddInc: begin b_op = b_i;   cin = 1'b1; end
            FsAddNot: begin b_op = ~b_i;  cin = 1'b0; end
            FsSub:    begin b_op = ~b_i;  cin = 1'b1; end
            FsDec:    begin b_op = '1;    cin = 1'b0; end
            default:  is_add = 1'b0;
        endcase
    end

    assign sum     = {1'b0, a_i} + {1'b0, b_op} + {{DataW{1'b0}}, cin};
    assign add_ovf = (a_i[DataW-1] == b_op[DataW-1]) && (sum[DataW-1] != a_i[DataW-1]);

    always_comb begin
        f_o = '0;
        c_o = 1'b0;
        v_o = 1'b0;
        if (is_add) begin
            f_o = sum[DataW-1:0];
            c_o = sum[DataW];
            v_o = add_ovf;
        end else begin
            case (fs_i)
                FsPassA, FsPassA2: f_o = a_i;
                FsAnd:   f_o = a_i & b_i;
                FsOr:    f_o = a_i | b_i;
                FsXor:   f_o = a_i ^ b_i;
                FsNotA:  f_o = ~a_i;
                FsPassB: f_o = b_i;
                FsLsr: begin
                    f_o = {1'b0, b_i[DataW-1:1]};
                    c_o = b_i[0];
                end
                FsShl: begin
                    f_o = {b_i[DataW-2:0], 1'b0};
                    c_o = b_i[DataW-1];
                end
                FsAsr: begin
                    f_o = {b_i[DataW-1], b_i[DataW-1:1]};
                    c_o = b_i[0];
                end
                FsSlt:   f_o = {{(DataW-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
                FsSltu:  f_o = {{(DataW-1){1'b0}}, (a_i < b_i)};
                default: f_o = '0;
            endcase
        end
    end

    assign n_o = f_o[DataW-1];
    assign z_o = (f_o == '0);

endmodule

// File: rtl/datapath_top.sv
// datapath_top: single-cycle microcoded datapath. 16x32 register file,
// constant mux, ALU, 256x32 data memory and a 4-bit status register.
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rst_n       : synchronous active-low reset; clears registers, memory, status
//   ControlWord : 55-bit microinstruction for this cycle
//   a_bus       : register-file port A (also the memory address source)
//   b_bus       : B bus after the constant mux (also memory write data)
//   d_bus       : write-back value
//   status      : registered flags {V,C,N,Z}
module datapath_top
    import datapath_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CwW-1:0]   ControlWord,
    output logic [DataW-1:0] a_bus,
    output logic [DataW-1:0] b_bus,
    output logic [DataW-1:0] d_bus,
    output logic [3:0]       status
);

    cw_t                 cw;
    logic [DataW-1:0]    rf_q  [NumRegs];
    logic [DataW-1:0]    mem_q [MemDepth];
    logic [3:0]          status_q;
    logic [3:0]          status_d;
    logic [MemAddrW-1:0] mem_addr;
    logic [DataW-1:0]    alu_f;
    logic                alu_v;
    logic                alu_c;
    logic                alu_n;
    logic                alu_z;

    assign cw = decode_cw(ControlWord);

    assign a_bus    = rf_q[cw.aa];
    assign b_bus    = cw.mb ? cw.k : rf_q[cw.ba];
    assign mem_addr = a_bus[MemAddrW-1:0];

    datapath_alu u_alu (
        .a_i  (a_bus),
        .b_i  (b_bus),
        .fs_i (cw.fs),
        .f_o  (alu_f),
        .v_o  (alu_v),
        .c_o  (alu_c),
        .n_o  (alu_n),
        .z_o  (alu_z)
    );

    assign d_bus    = cw.md ? mem_q[mem_addr] : alu_f;
    assign status_d = cw.se ? {alu_v, alu_c, alu_n, alu_z} : status_q;
    assign status   = status_q;

    // Reset takes priority so an unknown ControlWord cannot write during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
            for (int j = 0; j < MemDepth; j++) begin
                mem_q[j] <= '0;
            end
            status_q <= '0;
        end else begin
            if (cw.rw) begin
                rf_q[cw.da] <= d_bus;
            end
            if (cw.mw) begin
                mem_q[mem_addr] <= b_bus;
            end
            status_q <= status_d;
        end
    end

    // Upper address bits and the reserved control bit are ignored by design.
    logic unused_ok;
    assign unused_ok = ^{a_bus[DataW-1:MemAddrW], ControlWord[32]};

endmodule

// File: tb/tb_datapath_top.sv
// tb_datapath_top: randomized self-checking bench for datapath_top with a
// behavioural reference model, plus directed scenarios with literal expectations.
module tb_datapath_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [54:0] ControlWord = '0;
    logic [31:0] a_bus, b_bus, d_bus;
    logic [3:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference state
    logic [31:0] m_rf  [16];
    logic [31:0] m_mem [256];
    logic [3:0]  m_status;

    datapath_top dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ControlWord (ControlWord),
        .a_bus       (a_bus),
        .b_bus       (b_bus),
        .d_bus       (d_bus),
        .status      (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [54:0] mk(input int da, input int aa, input int ba, input int mb,
                                       input int fs, input int md, input int rw, input int mw,
                                       input int se, input logic [31:0] k);
        logic [54:0] w;
        logic [3:0]  da4, aa4, ba4;
        logic [4:0]  fs5;
        da4 = da[3:0];
        aa4 = aa[3:0];
        ba4 = ba[3:0];
        fs5 = fs[4:0];
        w = '0;
        w[54:51] = da4;
        w[50:47] = aa4;
        w[46:43] = ba4;
        w[42]    = mb[0];
        w[41:37] = fs5;
        w[36]    = md[0];
        w[35]    = rw[0];
        w[34]    = mw[0];
        w[33]    = se[0];
        w[31:0]  = k;
        return w;
    endfunction

    function automatic bit out_of_range(input longint x);
        return (x > 64'sd2147483647) || (x < -64'sd2147483648);
    endfunction

    // Returns {V, C, F} from plain integer arithmetic on the operands.
    function automatic logic [33:0] ref_alu(input logic [4:0] fs, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [31:0]     f;
        logic            c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        f = 32'h0; c = 1'b0; v = 1'b0;
        case (fs)
            5'd0, 5'd7: f = a;
            5'd1: begin f = a + 1;     c = (a == 32'hFFFF_FFFF);    v = out_of_range(sa + 1); end
            5'd2: begin f = a + b;     c = ((ua + ub) >> 32) != 0;  v = out_of_range(sa + sb); end
            5'd3: begin f = a + b + 1; c = ((ua + ub + 1) >> 32) != 0; v = out_of_range(sa + sb + 1); end
            5'd4: begin f = a - b - 1; c = (ua > ub);   v = out_of_range(sa - sb - 1); end
            5'd5: begin f = a - b;     c = (ua >= ub);  v = out_of_range(sa - sb); end
            5'd6: begin f = a - 1;     c = (a != 0);    v = out_of_range(sa - 1); end
            5'd8:  f = a & b;
            5'd9:  f = a | b;
            5'd10: f = a ^ b;
            5'd11: f = ~a;
            5'd12: f = b;
            5'd13: begin f = b >> 1; c = b[0]; end
            5'd14: begin f = b << 1; c = b[31]; end
            5'd15: begin f = $unsigned($signed(b) >>> 1); c = b[0]; end
            5'd16: f = (sa < sb) ? 32'd1 : 32'd0;
            5'd17: f = (ua < ub) ? 32'd1 : 32'd0;
            default: f = 32'h0;
        endcase
        return {v, c, f};
    endfunction

    // Expected combinational outputs for the present model state and control word.
    task automatic model_outputs(input logic [54:0] w, output logic [31:0] ea,
                                 output logic [31:0] eb, output logic [31:0] ed,
                                 output logic [3:0] flags);
        logic [33:0] r;
        logic [7:0]  addr;
        ea   = m_rf[w[50:47]];
        eb   = w[42] ? w[31:0] : m_rf[w[46:43]];
        r    = ref_alu(w[41:37], ea, eb);
        addr = ea[7:0];
        ed   = w[36] ? m_mem[addr] : r[31:0];
        flags = {r[33], r[32], r[31], (r[31:0] == 32'h0)};
    endtask

    // Model state update
    always @(posedge clk) begin
        logic [31:0] ea, eb, ed;
        logic [3:0]  fl;
        logic [7:0]  addr;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_rf[i] <= '0;
            for (int j = 0; j < 256; j++) m_mem[j] <= '0;
            m_status <= '0;
        end else begin
            model_outputs(ControlWord, ea, eb, ed, fl);
            addr = ea[7:0];
            if (ControlWord[35]) m_rf[ControlWord[54:51]] <= ed;
            if (ControlWord[34]) m_mem[addr] <= eb;
            if (ControlWord[33]) m_status <= fl;
        end
    end

    // Compare process
    always @(negedge clk) begin
        logic [31:0] ea, eb, ed;
        logic [3:0]  fl;
        if (chk_en) begin
            model_outputs(ControlWord, ea, eb, ed, fl);
            check("a_bus", a_bus, ea);
            check("b_bus", b_bus, eb);
            check("d_bus", d_bus, ed);
            check("status", {28'h0, status}, {28'h0, m_status});
        end
    end

    // Apply a control word just after the rising edge; return just after the falling edge.
    task automatic apply(input logic [54:0] w, input logic rn);
        @(posedge clk);
        #1;
        ControlWord = w;
        rst_n = rn;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [33:0] r;
        logic [63:0] rnd;
        logic [54:0] w;

        // Pin the reference ALU against hand-computed values
        r = ref_alu(5'd5, 32'd5, 32'd7);
        check("ref_sub", {r[33:32], 30'h0}, {2'b00, 30'h0});
        check("ref_sub_f", r[31:0], 32'hFFFF_FFFE);
        r = ref_alu(5'd1, 32'h7FFF_FFFF, 32'h0);
        check("ref_inc_ovf", {r[33:32], 30'h0}, {2'b10, 30'h0});
        r = ref_alu(5'd15, 32'h0, 32'h8000_0001);
        check("ref_asr", r[31:0], 32'hC000_0000);
        r = ref_alu(5'd16, 32'hFFFF_FFFF, 32'h1);
        check("ref_slt", r[31:0], 32'h1);

        // Reset for two cycles
        apply(mk(3, 3, 3, 1, 12, 0, 1, 1, 1, 32'h1234), 1'b0);
        apply(mk(3, 3, 3, 1, 12, 0, 1, 1, 1, 32'h1234), 1'b0);
        chk_en = 1'b1;
        check("reset_status", {28'h0, status}, 32'h0);

        // Constant loads and observation latency
        apply(mk(1, 0, 0, 1, 12, 0, 1, 0, 0, 32'd5), 1'b1);
        check("reset_a_bus", a_bus, 32'h0);
        apply(mk(2, 1, 0, 1, 12, 0, 1, 0, 0, 32'd7), 1'b1);
        check("load_r1", a_bus, 32'd5);

        // Register add
        apply(mk(3, 1, 2, 0, 2, 0, 1, 0, 1, 32'h0), 1'b1);
        check("add_d_bus", d_bus, 32'd12);
        apply(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0), 1'b1);
        check("add_r3", a_bus, 32'd12);
        check("add_status", {28'h0, status}, 32'h0);

        // Subtract with flags
        apply(mk(0, 1, 2, 0, 5, 0, 0, 0, 1, 32'h0), 1'b1);
        check("sub_d_bus", d_bus, 32'hFFFF_FFFE);
        apply(mk(4, 0, 0, 1, 12, 0, 1, 0, 0, 32'h10), 1'b1);
        check("sub_status", {28'h0, status}, 32'h2);

        // Memory round trip
        apply(mk(5, 0, 0, 1, 12, 0, 1, 0, 0, 32'hDEAD_BEEF), 1'b1);
        apply(mk(0, 4, 5, 0, 0, 0, 0, 1, 0, 32'h0), 1'b1);
        check("mem_wdata", b_bus, 32'hDEAD_BEEF);
        apply(mk(6, 4, 0, 0, 0, 1, 1, 0, 0, 32'h0), 1'b1);
        check("mem_rd", d_bus, 32'hDEAD_BEEF);
        apply(mk(7, 6, 0, 1, 12, 0, 1, 0, 0, 32'h7FFF_FFFF), 1'b1);
        check("mem_r6", a_bus, 32'hDEAD_BEEF);

        // Overflow on increment
        apply(mk(0, 7, 0, 0, 1, 0, 0, 0, 1, 32'h0), 1'b1);
        check("inc_ovf_f", d_bus, 32'h8000_0000);
        // Arithmetic shift right
        apply(mk(0, 0, 0, 1, 15, 0, 0, 0, 1, 32'h8000_0001), 1'b1);
        check("inc_ovf_status", {28'h0, status}, 32'hA);
        check("asr_f", d_bus, 32'hC000_0000);
        // SE=0 with a zero result: status must hold
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), 1'b1);
        check("asr_status", {28'h0, status}, 32'h6);
        check("zero_f", d_bus, 32'h0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0), 1'b1);
        check("hold_status", {28'h0, status}, 32'h6);

        // Mid-stream reset with a pending write
        apply(mk(1, 1, 0, 1, 12, 0, 1, 1, 1, 32'd99), 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply(mk(0, i, 0, 0, 0, 0, 0, 0, 0, 32'h0), 1'b1);
            check("post_reset_reg", a_bus, 32'h0);
        end
        check("post_reset_status", {28'h0, status}, 32'h0);
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0), 1'b1);
        check("post_reset_mem", d_bus, 32'h0);

        // Randomized stream; small constants keep memory addresses colliding
        for (int n = 0; n < 600; n++) begin
            rnd = {$urandom(), $urandom()};
            w = rnd[54:0];
            if ($urandom_range(0, 2) == 0) w[31:0] = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) w[41:37] = 5'($urandom_range(0, 17));
            apply(w, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
